// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - two-requester arbiter for the single regfile port
//
// Shares the one read/write port of the 16x32 register file between the core
// datapath (requester A) and the debug controller (requester B). Every accepted
// request is issued on the port for one cycle. The result then returns to the
// owning requester: the read data, or the echoed write data for a write.
//
// Optional feature macro: REGFILE_ARB_RR_EN
//   defined     - round-robin between A and B when both request
//   not defined - fixed priority, A always beats B (no pointer state)
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   a_req/a_write/a_addr/a_wdata   requester A transaction (held until a_grant)
//   a_grant                  one-cycle pulse: A's request accepted and issued
//   a_rvalid/a_rdata         one-cycle completion pulse; rdata holds between pulses
//   b_*                      identical set for requester B
//   port_addr/port_write/port_wdata   regfile port drive (registered)
//   port_rdata               regfile read data for port_addr
//   busy                     high while a transaction is in ISSUE
module regfile_port_arbiter (
  input  logic        clk,
  input  logic        rst,

  input  logic        a_req,
  input  logic        a_write,
  input  logic [3:0]  a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_grant,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,

  input  logic        b_req,
  input  logic        b_write,
  input  logic [3:0]  b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_grant,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,

  output logic [3:0]  port_addr,
  output logic        port_write,
  output logic [31:0] port_wdata,
  input  logic [31:0] port_rdata,

  output logic        busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t      state, state_next;

  // owner: 0 = A, 1 = B
  logic        owner, owner_next;
  logic        pick_b;

  logic        a_grant_next, b_grant_next;
  logic        a_rvalid_next, b_rvalid_next;
  logic [31:0] a_rdata_next, b_rdata_next;
  logic [3:0]  port_addr_next;
  logic        port_write_next;
  logic [31:0] port_wdata_next;
  logic [31:0] result;

`ifdef REGFILE_ARB_RR_EN
  // ptr: 0 = A holds priority, 1 = B holds priority
  logic        ptr, ptr_next;

  assign pick_b = b_req && (!a_req || ptr);
`else
  assign pick_b = b_req && !a_req;
`endif

  // A write returns its own data; a read returns what the regfile presents
  // for the address driven since the previous edge.
  assign result = port_write ? port_wdata : port_rdata;

  assign busy = (state == ISSUE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      a_grant    <= 1'b0;
      b_grant    <= 1'b0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
      port_addr  <= '0;
      port_write <= 1'b0;
      port_wdata <= '0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      a_grant    <= a_grant_next;
      b_grant    <= b_grant_next;
      a_rvalid   <= a_rvalid_next;
      b_rvalid   <= b_rvalid_next;
      a_rdata    <= a_rdata_next;
      b_rdata    <= b_rdata_next;
      port_addr  <= port_addr_next;
      port_write <= port_write_next;
      port_wdata <= port_wdata_next;
    end
  end

`ifdef REGFILE_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else begin
      ptr <= ptr_next;
    end
  end
`endif

  always_comb begin
    state_next      = state;
    owner_next      = owner;
    a_grant_next    = 1'b0;
    b_grant_next    = 1'b0;
    a_rvalid_next   = 1'b0;
    b_rvalid_next   = 1'b0;
    a_rdata_next    = a_rdata;
    b_rdata_next    = b_rdata;
    port_addr_next  = port_addr;
    port_write_next = 1'b0;
    port_wdata_next = port_wdata;
`ifdef REGFILE_ARB_RR_EN
    ptr_next        = ptr;
`endif

    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          owner_next = pick_b;
          if (pick_b) begin
            port_addr_next  = b_addr;
            port_write_next = b_write;
            port_wdata_next = b_wdata;
            b_grant_next    = 1'b1;
          end else begin
            port_addr_next  = a_addr;
            port_write_next = a_write;
            port_wdata_next = a_wdata;
            a_grant_next    = 1'b1;
          end
`ifdef REGFILE_ARB_RR_EN
          // Priority passes to whichever requester did not just win.
          ptr_next = !pick_b;
`endif
          state_next = ISSUE;
        end
      end

      ISSUE: begin
        // Requests are not sampled here; a held request wins in the next IDLE.
        if (owner) begin
          b_rvalid_next = 1'b1;
          b_rdata_next  = result;
        end else begin
          a_rvalid_next = 1'b1;
          a_rdata_next  = result;
        end
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
